// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART FIFOs, cycle counter and program-stop.
// Build option CYCLE_SNAPSHOT_EN: a 0x30004 read latches the counter so 4-byte reads are coherent.
module mem_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        program_stop,
   output logic [31:0] cycle_count
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_ALMOST   = (TX_AW+1)'(TX_DEPTH - 2);
   localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

   function automatic logic [7:0] dword_byte(input logic [31:0] w, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   logic [7:0]            ram_r [2**ADDR_WIDTH];
   logic [7:0]            ram_rdata_r;
   logic                  ram_sel_r;
   logic [7:0]            io_rdata_r;
   logic [7:0]            io_rdata_s;
   logic [7:0]            cnt_byte_s;
   logic [ADDR_WIDTH-1:0] ram_idx_s;
   logic                  is_ram_s, is_io_s, io_uart_s, io_cnt_s, rd_s, wr_s;
   logic                  unused_s;

   logic [7:0]   tx_mem_r [TX_DEPTH];
   logic [TX_AW:0] tx_wr_r, tx_rd_r, tx_wr_nx_s, tx_rd_nx_s, tx_cnt_nx_s;
   logic         tx_empty_s, tx_full_s, tx_pop_s, tx_push_s, tx_push_req_s, stop_set_s;
   logic [7:0]   tx_push_data_s;
   logic         tx_valid_r, io_buffer_full_r;

   logic [7:0]   rx_mem_r [RX_DEPTH];
   logic [RX_AW:0] rx_wr_r, rx_rd_r, rx_wr_nx_s, rx_rd_nx_s, rx_cnt_nx_s;
   logic         rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_ready_r;

   logic         program_stop_r;
   logic [31:0]  cycle_count_r;

   assign unused_s  = ^mem_a[31:18];
   assign ram_idx_s = mem_a[ADDR_WIDTH-1:0];
   assign is_ram_s  = (mem_a[17] == 1'b0);
   assign is_io_s   = (mem_a[17:16] == 2'b11);
   assign io_uart_s = is_io_s && (mem_a[15:0] == 16'h0000);
   assign io_cnt_s  = is_io_s && (mem_a[15:2] == 14'h0001);
   assign rd_s      = !mem_wr;
   assign wr_s      = mem_wr;

`ifdef CYCLE_SNAPSHOT_EN
   logic [31:0] snapshot_r;

   // Latch the live counter on a byte-0 read so the following byte reads see one value.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         snapshot_r <= 32'h0000_0000;
      end else if (rd_s && io_cnt_s && (mem_a[1:0] == 2'b00)) begin
         snapshot_r <= cycle_count_r;
      end
   end

   assign cnt_byte_s = (mem_a[1:0] == 2'b00) ? cycle_count_r[7:0]
                                             : dword_byte(snapshot_r, mem_a[1:0]);
`else
   assign cnt_byte_s = dword_byte(cycle_count_r, mem_a[1:0]);
`endif

   assign tx_empty_s  = (tx_wr_r == tx_rd_r);
   assign tx_full_s   = ((tx_wr_r - tx_rd_r) == TX_FULL_CNT);
   assign tx_pop_s    = !tx_empty_s && tx_ready;
   assign tx_push_s   = tx_push_req_s && (!tx_full_s || tx_pop_s);
   assign tx_wr_nx_s  = tx_wr_r + (TX_AW+1)'(tx_push_s);
   assign tx_rd_nx_s  = tx_rd_r + (TX_AW+1)'(tx_pop_s);
   assign tx_cnt_nx_s = tx_wr_nx_s - tx_rd_nx_s;

   assign rx_empty_s  = (rx_wr_r == rx_rd_r);
   assign rx_full_s   = ((rx_wr_r - rx_rd_r) == RX_FULL_CNT);
   assign rx_pop_s    = rd_s && io_uart_s && !rx_empty_s;
   assign rx_push_s   = rx_valid && !rx_full_s;
   assign rx_wr_nx_s  = rx_wr_r + (RX_AW+1)'(rx_push_s);
   assign rx_rd_nx_s  = rx_rd_r + (RX_AW+1)'(rx_pop_s);
   assign rx_cnt_nx_s = rx_wr_nx_s - rx_rd_nx_s;

   // Decode CPU writes that feed the TX FIFO; a stop write queues a trailing 0x00.
   always_comb begin
      tx_push_req_s  = 1'b0;
      tx_push_data_s = 8'h00;
      stop_set_s     = 1'b0;
      if (wr_s && io_uart_s) begin
         tx_push_req_s  = (mem_dout != 8'h00);
         tx_push_data_s = mem_dout;
      end else if (wr_s && io_cnt_s && (mem_a[1:0] == 2'b00)) begin
         tx_push_req_s  = 1'b1;
         stop_set_s     = 1'b1;
      end else begin
         tx_push_req_s  = 1'b0;
         stop_set_s     = 1'b0;
      end
   end

   // I/O read mux; anything unmapped or out of range reads as zero.
   always_comb begin
      io_rdata_s = 8'h00;
      if (rd_s && io_uart_s) begin
         if (!rx_empty_s) begin
            io_rdata_s = rx_mem_r[rx_rd_r[RX_AW-1:0]];
         end else begin
            io_rdata_s = 8'h00;
         end
      end else if (rd_s && io_cnt_s) begin
         io_rdata_s = cnt_byte_s;
      end else begin
         io_rdata_s = 8'h00;
      end
   end

   // Byte RAM with a synchronous read port; contents survive reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in && wr_s && is_ram_s) begin
         ram_r[ram_idx_s] <= mem_dout;
      end
      ram_rdata_r <= ram_r[ram_idx_s];
   end

   // FIFO storage carries no reset; the pointers alone define valid content.
   always_ff @(posedge clk_in) begin
      if (!rst_in && tx_push_s) begin
         tx_mem_r[tx_wr_r[TX_AW-1:0]] <= tx_push_data_s;
      end
      if (!rst_in && rx_push_s) begin
         rx_mem_r[rx_wr_r[RX_AW-1:0]] <= rx_data;
      end
   end

   // Pointers, status flags, counter and read-data selection.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tx_wr_r          <= {(TX_AW+1){1'b0}};
         tx_rd_r          <= {(TX_AW+1){1'b0}};
         rx_wr_r          <= {(RX_AW+1){1'b0}};
         rx_rd_r          <= {(RX_AW+1){1'b0}};
         tx_valid_r       <= 1'b0;
         io_buffer_full_r <= 1'b0;
         rx_ready_r       <= 1'b1;
         program_stop_r   <= 1'b0;
         cycle_count_r    <= 32'h0000_0000;
         ram_sel_r        <= 1'b0;
         io_rdata_r       <= 8'h00;
      end else begin
         tx_wr_r          <= tx_wr_nx_s;
         tx_rd_r          <= tx_rd_nx_s;
         rx_wr_r          <= rx_wr_nx_s;
         rx_rd_r          <= rx_rd_nx_s;
         tx_valid_r       <= (tx_wr_nx_s != tx_rd_nx_s);
         io_buffer_full_r <= (tx_cnt_nx_s >= TX_ALMOST);
         rx_ready_r       <= (rx_cnt_nx_s != RX_FULL_CNT);
         program_stop_r   <= program_stop_r | stop_set_s;
         cycle_count_r    <= cycle_count_r + 32'd1;
         ram_sel_r        <= rd_s && is_ram_s;
         io_rdata_r       <= io_rdata_s;
      end
   end

   assign mem_din        = ram_sel_r ? ram_rdata_r : io_rdata_r;
   assign io_buffer_full = io_buffer_full_r;
   assign tx_valid       = tx_valid_r;
   assign tx_data        = tx_mem_r[tx_rd_r[TX_AW-1:0]];
   assign rx_ready       = rx_ready_r;
   assign program_stop   = program_stop_r;
   assign cycle_count    = cycle_count_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a per-cycle bus model predicts mem_din, the TX byte stream and status flags.
module tb_mem_io_responder;

   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_CNT  = 32'h0003_0004;
   localparam logic [31:0] A_IDLE = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        program_stop;
   logic [31:0] cycle_count;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [7:0]  din_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_m[$];
   logic [7:0]  ram_m [int];
   logic [31:0] cyc_m  = 32'h0;
   logic [31:0] snap_m = 32'h0;
   logic        stop_m = 1'b0;

   mem_io_responder dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .program_stop   (program_stop),
      .cycle_count    (cycle_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: predict this cycle's effects, clock, then compare all outputs.
   task automatic tick();
      logic [7:0]  exp_din;
      logic [17:0] a;
      int          rx_n0;
      bit          pop_tx;
      exp_din = 8'h00;
      a       = mem_a[17:0];
      rx_n0   = rx_m.size();
      pop_tx  = (tx_valid === 1'b1) && (tx_ready === 1'b1) && !rst_in;
      if (pop_tx) begin
         if (tx_q.size() > 0) check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
         else check("tx_data_unexpected", {24'h0, tx_data}, 32'h100);
      end
      if (!rst_in) begin
         if (mem_wr) begin
            if (a[17] == 1'b0) begin
               ram_m[int'(a[16:0])] = mem_dout;
            end else if (a == 18'h30000) begin
               if (mem_dout != 8'h00 && tx_q.size() < 16) tx_q.push_back(mem_dout);
            end else if (a == 18'h30004) begin
               stop_m = 1'b1;
               if (tx_q.size() < 16) tx_q.push_back(8'h00);
            end
         end else begin
            if (a[17] == 1'b0) begin
               exp_din = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
            end else if (a == 18'h30000) begin
               if (rx_n0 > 0) exp_din = rx_m.pop_front();
            end else if (a[17:2] == 16'hC001) begin
`ifdef CYCLE_SNAPSHOT_EN
               if (a[1:0] == 2'b00) begin
                  snap_m  = cyc_m;
                  exp_din = cyc_m[7:0];
               end else begin
                  exp_din = 8'(snap_m >> (8 * int'(a[1:0])));
               end
`else
               exp_din = 8'(cyc_m >> (8 * int'(a[1:0])));
`endif
            end
         end
         if (rx_valid && rx_n0 < 16) rx_m.push_back(rx_data);
      end
      din_q.push_back(exp_din);
      @(posedge clk);
      #1;
      if (rst_in) begin
         tx_q.delete();
         rx_m.delete();
         stop_m = 1'b0;
         cyc_m  = 32'h0;
         snap_m = 32'h0;
      end else begin
         cyc_m = cyc_m + 32'd1;
      end
      check("mem_din", {24'h0, mem_din}, {24'h0, din_q.pop_front()});
      check("cycle_count", cycle_count, cyc_m);
      check("tx_valid", {31'h0, tx_valid}, 32'(tx_q.size() != 0));
      check("io_buffer_full", {31'h0, io_buffer_full}, 32'(tx_q.size() >= 14));
      check("rx_ready", {31'h0, rx_ready}, 32'(rx_m.size() < 16));
      check("program_stop", {31'h0, program_stop}, {31'h0, stop_m});
   endtask

   task automatic go_idle();
      mem_a    = A_IDLE;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [7:0] d);
      mem_a    = addr;
      mem_wr   = 1'b1;
      mem_dout = d;
      tick();
      go_idle();
   endtask

   task automatic rd(input logic [31:0] addr);
      mem_a  = addr;
      mem_wr = 1'b0;
      tick();
      go_idle();
   endtask

   initial begin
      rst_in   = 1'b1;
      tx_ready = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      go_idle();
      tick();
      tick();
      rst_in = 1'b0;
      check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("reset_count", cycle_count, 32'h0);

      // RAM round trip, same-address read right after write, out-of-range window
      wr(32'h0000_0100, 8'hA5);
      rd(32'h0000_0100);
      check("ram_roundtrip", {24'h0, mem_din}, 32'hA5);
      wr(32'h0002_0100, 8'h5A);
      rd(32'h0002_0000);
      check("oob_read", {24'h0, mem_din}, 32'h0);
      rd(32'h0000_0100);
      check("oob_write_ignored", {24'h0, mem_din}, 32'hA5);

      // UART out: 0x00 data is swallowed, stop write appends 0x00
      wr(A_UART, 8'h48);
      wr(A_UART, 8'h00);
      wr(A_UART, 8'h69);
      for (int i = 0; i < 4; i++) tick();
      wr(A_CNT, 8'hFF);
      check("stop_set", {31'h0, program_stop}, 32'h1);
      for (int i = 0; i < 4; i++) tick();

      // Reset with five bytes queued
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) wr(A_UART, 8'(i));
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_count", cycle_count, 32'h0);
      check("rst_stop", {31'h0, program_stop}, 32'h0);
      tx_ready = 1'b1;
      rd(32'h0000_0100);
      check("ram_after_reset", {24'h0, mem_din}, 32'hA5);

      // RX: two bytes, then an empty read
      rx_valid = 1'b1;
      rx_data  = 8'h31;
      tick();
      rx_data  = 8'h32;
      tick();
      rx_valid = 1'b0;
      rd(A_UART);
      check("rx_first", {24'h0, mem_din}, 32'h31);
      rd(A_UART);
      check("rx_second", {24'h0, mem_din}, 32'h32);
      rd(A_UART);
      check("rx_empty", {24'h0, mem_din}, 32'h0);

      // RX fill past full, pop while full, pop-with-push on last entry
      rx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         rx_data = 8'(8'h40 + i);
         tick();
      end
      check("rx_full", {31'h0, rx_ready}, 32'h0);
      rx_data = 8'hEE;
      rd(A_UART);
      rx_valid = 1'b0;
      check("rx_pop_full", {24'h0, mem_din}, 32'h40);
      for (int i = 0; i < 14; i++) rd(A_UART);
      rx_valid = 1'b1;
      rx_data  = 8'hAB;
      rd(A_UART);
      rx_valid = 1'b0;
      check("rx_last_old", {24'h0, mem_din}, 32'h4F);
      rd(A_UART);
      check("rx_pushed", {24'h0, mem_din}, 32'hAB);
      rd(A_UART);
      check("rx_drained", {24'h0, mem_din}, 32'h0);

      // TX backpressure, overflow drop, push+pop while full, ordered drain
      tx_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         wr(A_UART, 8'(8'h10 + i));
         if (i == 12) check("bp_not_full13", {31'h0, io_buffer_full}, 32'h0);
      end
      check("bp_full14", {31'h0, io_buffer_full}, 32'h1);
      wr(A_UART, 8'h20);
      wr(A_UART, 8'h21);
      wr(A_UART, 8'h22);
      tx_ready = 1'b1;
      wr(A_UART, 8'h77);
      for (int i = 0; i < 40 && tx_valid; i++) tick();
      check("bp_drained", {31'h0, tx_valid}, 32'h0);

      // Counter bytes read over four cycles from 0xFE
      for (int i = 0; i < 2000 && cyc_m != 32'hFE; i++) tick();
      check("cnt_start", cycle_count, 32'hFE);
      rd(A_CNT);
      check("cnt_b0", {24'h0, mem_din}, 32'hFE);
      rd(A_CNT + 32'd1);
      check("cnt_b1", {24'h0, mem_din}, 32'h0);
      rd(A_CNT + 32'd2);
      check("cnt_b2", {24'h0, mem_din}, 32'h0);
      rd(A_CNT + 32'd3);
      check("cnt_b3", {24'h0, mem_din}, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the CPU's byte-wide memory bus: the end that services mem_a/mem_wr/mem_dout and returns mem_din and io_buffer_full.
- Contains the byte RAM.
- Decodes the I/O window: UART TX/RX byte FIFOs, cycle counter, program-stop.
- Sits between the cpu top and the board/UART wrapper; replaces the bus model in simulation and on FPGA.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (RAM size 2^ADDR_WIDTH bytes).
TX_DEPTH, 16, TX FIFO entries (power of 2, >=4).
RX_DEPTH, 16, RX FIFO entries (power of 2, >=2).

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous, active-high reset
mem_a  in  32  CPU address (only [17:0] decoded)
mem_wr  in  1  1 = write, 0 = read
mem_dout  in  8  CPU write data
mem_din  out  8  read data to CPU (registered)
io_buffer_full  out  1  TX FIFO almost full, to CPU
tx_valid  out  1  TX byte available
tx_data  out  8  TX FIFO head
tx_ready  in  1  UART accepts tx_data
rx_valid  in  1  UART offers rx_data
rx_data  in  8  received byte
rx_ready  out  1  RX FIFO not full
program_stop  out  1  sticky, set by write to 0x30004
cycle_count  out  32  free-running cycle counter

Behaviour:
- One clock, clk_in. rst_in is synchronous, active-high.
- Reset values:
  - mem_din=0, tx_valid=0, io_buffer_full=0, program_stop=0, cycle_count=0; FIFOs empty.
  - rx_ready=1 from the first cycle after reset.
  - RAM contents are not reset.
- Address decode:
  - io = (mem_a[17:16]==2'b11).
  - RAM when mem_a[17:16] is 00 or 01, index mem_a[ADDR_WIDTH-1:0].
  - mem_a[17:16]==10: out of range; reads return 0, writes ignored.
- Read (mem_wr=0): the byte for the address sampled in cycle N appears on mem_din in cycle N+1 (latency 1, every cycle, no handshake).
  - RAM region: stored byte.
  - 0x30000: RX FIFO head, popped in cycle N. If RX is empty, return 0 and do not pop.
  - 0x30004–0x30007: byte mem_a[1:0] of the counter dword, little-endian (see Optional Feature).
  - Other io addresses: 0.
- Write (mem_wr=1): committed at the end of cycle N; mem_din shows 0 in N+1.
  - RAM region: byte stored. A read of the same address in N+1 returns the new value.
  - 0x30000: a nonzero byte is pushed to TX; 0x00 is ignored.
  - 0x30004: sets program_stop (sticky until reset) and pushes 0x00 to TX.
  - Push into a full TX FIFO: byte is dropped, no other effect.
  - Other io writes are ignored.
- io_buffer_full = (TX count >= TX_DEPTH-2), registered.
  - The 2-entry margin absorbs writes already in the CPU pipeline.
- TX FIFO:
  - tx_valid = not empty; tx_data = head.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop: count unchanged, both take effect, including when full.
- RX FIFO:
  - rx_ready = not full; push on rx_valid && rx_ready.
  - Simultaneous CPU pop and UART push: count unchanged.
  - Pop from an RX FIFO holding one entry while a push arrives: next read returns the pushed byte.
- cycle_count:
  - +1 every cycle after reset, wraps 0xFFFFFFFF -> 0.
  - Continues counting after program_stop.
- Pointer wrap: read/write pointers are ADDR-bit counters modulo depth; full/empty use an extra wrap bit.
- Reset mid-operation: pending mem_din and both FIFOs are cleared next cycle; in-flight UART bytes are lost.

Optional Feature:
CYCLE_SNAPSHOT_EN
- Defined:
  - A read of 0x30004 latches cycle_count into a 32-bit snapshot and returns byte 0 of the value latched.
  - Reads of 0x30005–0x30007 return bytes of the snapshot, so a 4-byte read sequence is coherent.
  - The snapshot resets to 0.
- Undefined:
  - No snapshot register.
  - Every byte read returns the corresponding byte of the live cycle_count in cycle N.

Test Plan:
- RAM round-trip: write 0xA5 @0x00100, then read @0x00100 -> mem_din=0xA5 exactly one cycle after the read cycle. Read @0x20000 -> 0x00.
- UART out: writes 0x48, 0x00, 0x69 @0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only. Write @0x30004 -> program_stop=1 and a trailing 0x00 on tx.
- TX backpressure: tx_ready=0, write 14 nonzero bytes -> io_buffer_full=1 after the 14th. 3 more writes -> count stops at 16, one byte dropped. Raise tx_ready -> 16 bytes drain in order, io_buffer_full falls when count<14.
- RX: rx_valid with 0x31 then 0x32; read 0x30000 three times -> 0x31, 0x32, 0x00. Fill 16 bytes -> rx_ready=0.
- Counter:
  - With CYCLE_SNAPSHOT_EN, read 0x30004..0x30007 over 4 cycles starting at count 0x000000FE -> bytes FE,00,00,00, coherent.
  - Without it -> byte 0 read in cycle N reflects the live count; bytes 1–3 show the live counter's upper bytes (00,00,00 here).
- Reset mid-transfer: assert rst_in for 1 cycle with TX holding 5 bytes -> tx_valid=0, cycle_count=0, program_stop=0 next cycle. RAM byte @0x00100 still 0xA5.
